// File: rtl/uart_pkg.sv
// Shared definitions for the serial-to-memory UART receiver: FSM states and frame format.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receive engine: input synchroniser, framing FSM and baud/bit counters.
// stop_ok is a same-cycle strobe on the stop-sample cycle so the memory write lands on the byte_valid edge.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       stop_ok,
    output logic [7:0] shreg_byte,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err_pulse,
    output logic       busy
);

    localparam int H  = (CLKS_PER_BIT - 1) / 2;
    localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT + 1);

    rx_state_t       state, state_n;
    logic            rxd_m, rxd_s;
    logic [CW-1:0]   baud_cnt, baud_n;
    logic [2:0]      bit_cnt, bit_n;
    logic [7:0]      shreg, shreg_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m      <= 1'b1;
            rxd_s      <= 1'b1;
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
        end else begin
            rxd_m      <= rxd;
            rxd_s      <= rxd_m;
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_cnt    <= bit_n;
            shreg      <= shreg_n;
            byte_valid <= stop_ok;
            if (stop_ok)
                byte_data <= shreg;
        end
    end

    // baud_cnt counts cycles since the last sample point; each sample fires when it reaches its target.
    always_comb begin
        state_n         = state;
        baud_n          = baud_cnt;
        bit_n           = bit_cnt;
        shreg_n         = shreg;
        stop_ok         = 1'b0;
        frame_err_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    baud_n = CW'(1);
                    bit_n  = '0;
                    state_n = (H == 0) ? DATA : START;
                end
            end
            START: begin
                if (baud_cnt == CW'(H)) begin
                    baud_n  = CW'(1);
                    bit_n   = '0;
                    state_n = rxd_s ? IDLE : DATA;
                end else begin
                    baud_n = baud_cnt + CW'(1);
                end
            end
            DATA: begin
                if (baud_cnt == CW'(CLKS_PER_BIT)) begin
                    shreg_n[bit_cnt] = rxd_s;
                    baud_n           = CW'(1);
                    if (bit_cnt == 3'(DATA_BITS - 1))
                        state_n = STOP;
                    else
                        bit_n = bit_cnt + 3'd1;
                end else begin
                    baud_n = baud_cnt + CW'(1);
                end
            end
            STOP: begin
                if (baud_cnt == CW'(CLKS_PER_BIT)) begin
                    baud_n = '0;
                    if (rxd_s == STOP_LVL) begin
                        stop_ok = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_err_pulse = 1'b1;
                        state_n         = BRK;
                    end
                end else begin
                    baud_n = baud_cnt + CW'(1);
                end
            end
            BRK: begin
                if (rxd_s)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign shreg_byte = shreg;
    assign busy       = (state != IDLE);

endmodule

// File: rtl/uart_rx_mem.sv
// UART receiver sink: stores good bytes sequentially into a small byte memory with a read-back port.
module uart_rx_mem
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int DEPTH        = 10,
    parameter int AW           = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rxd,
    input  logic          clr,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          byte_valid,
    output logic [7:0]    byte_data,
    output logic [AW:0]   count,
    output logic          ack,
    output logic          frame_err,
    output logic          overrun,
    output logic          busy
);

    logic          stop_ok;
    logic [7:0]    shreg_byte;
    logic          frame_err_pulse;
    logic          full;
    logic [AW-1:0] wr_ptr;
    logic [7:0]    mem [DEPTH];

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk             (clk),
        .rst_n           (rst_n),
        .rxd             (rxd),
        .stop_ok         (stop_ok),
        .shreg_byte      (shreg_byte),
        .byte_valid      (byte_valid),
        .byte_data       (byte_data),
        .frame_err_pulse (frame_err_pulse),
        .busy            (busy)
    );

    assign full = (count == (AW+1)'(DEPTH));
    assign ack  = full;

    // clr outranks a same-edge write, so the byte in flight is dropped but still reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (stop_ok) begin
                if (!full) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    count  <= count + (AW+1)'(1);
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (frame_err_pulse)
                frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (stop_ok && !clr && !full)
            mem[wr_ptr] <= shreg_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else if ({1'b0, rd_addr} < (AW+1)'(DEPTH))
            rd_data <= mem[rd_addr];
        else
            rd_data <= '0;
    end

endmodule

// File: tb/tb_uart_rx_mem.sv
// Directed scoreboard bench for uart_rx_mem: one-bit-per-clock instance plus an 8-clocks-per-bit instance.
module tb_uart_rx_mem;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd, clr;
    logic [3:0] rd_addr;
    logic [7:0] rd_data, byte_data;
    logic       byte_valid, ack, frame_err, overrun, busy;
    logic [4:0] count;

    logic       rxd8, clr8;
    logic [3:0] rd_addr8;
    logic [7:0] rd_data8, byte_data8;
    logic       byte_valid8, ack8, frame_err8, overrun8, busy8;
    logic [4:0] count8;

    int n_cmp  = 0;
    int n_fail = 0;
    int bv8_pulses = 0;
    logic [7:0] sb[$];
    logic [7:0] pat [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h80, 8'hC0};

    always #5 clk = ~clk;

    uart_rx_mem #(.CLKS_PER_BIT(1), .DEPTH(10), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .clr(clr), .rd_addr(rd_addr), .rd_data(rd_data),
        .byte_valid(byte_valid), .byte_data(byte_data), .count(count), .ack(ack),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    uart_rx_mem #(.CLKS_PER_BIT(8), .DEPTH(10), .AW(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd8), .clr(clr8), .rd_addr(rd_addr8), .rd_data(rd_data8),
        .byte_valid(byte_valid8), .byte_data(byte_data8), .count(count8), .ack(ack8),
        .frame_err(frame_err8), .overrun(overrun8), .busy(busy8)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame one bit per negedge; a good stop bit means a byte_valid is owed.
    task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit);
        if (stop_bit)
            sb.push_back(b);
        @(negedge clk) rxd = 1'b0;
        for (int k = 0; k < 8; k++)
            @(negedge clk) rxd = b[k];
        @(negedge clk) rxd = stop_bit;
    endtask

    task automatic send8(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk) rxd8 = frame[k];
            repeat (7) @(negedge clk);
        end
    endtask

    task automatic read_mem(input logic [3:0] addr, input logic [7:0] exp);
        @(negedge clk) rd_addr = addr;
        @(negedge clk);
        check_output($sformatf("mem[%0d]", addr), rd_data, exp);
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (byte_valid) begin
            if (sb.size() == 0) begin
                check_output("unexpected_byte_valid", byte_data, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] exp_b;
                exp_b = sb.pop_front();
                check_output("sb_byte_data", byte_data, exp_b);
            end
        end
        if (byte_valid8)
            bv8_pulses++;
    end

    initial begin
        rst_n = 1'b0; rxd = 1'b1; clr = 1'b0; rd_addr = '0;
        rxd8 = 1'b1; clr8 = 1'b0; rd_addr8 = '0;
        repeat (3) @(negedge clk);
        check_output("rst_count", count, 0);
        check_output("rst_bv_bd", {byte_valid, byte_data}, 0);
        check_output("rst_flags", {ack, frame_err, overrun, busy}, 0);
        check_output("rst_rd_data", rd_data, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] single frame latency");
        apply_stimulus(8'h0F, 1'b1);
        @(negedge clk) check_output("t1_bv_early0", byte_valid, 0);
        @(negedge clk) check_output("t1_bv_early1", byte_valid, 0);
        @(negedge clk) check_output("t1_bv_on_time", byte_valid, 1);
        check_output("t1_count", count, 1);
        read_mem(4'd0, 8'h0F);

        $display("[TB] fill and overrun");
        pulse_clr();
        check_output("t2_clr_count", count, 0);
        for (int i = 0; i < 10; i++)
            apply_stimulus(pat[i], 1'b1);
        repeat (4) @(negedge clk);
        check_output("t2_count_full", count, 10);
        check_output("t2_ack", ack, 1);
        check_output("t2_no_overrun", overrun, 0);
        for (int i = 0; i < 10; i++)
            read_mem(4'(i), pat[i]);
        read_mem(4'd10, 8'h00);
        read_mem(4'd15, 8'h00);
        apply_stimulus(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        check_output("t2_overrun", overrun, 1);
        check_output("t2_ovr_byte_data", byte_data, 8'h55);
        check_output("t2_ovr_count", count, 10);
        read_mem(4'd9, 8'hC0);
        read_mem(4'd0, 8'h01);

        $display("[TB] framing error and break");
        pulse_clr();
        check_output("t3_clr_flags", {ack, overrun, count}, 0);
        apply_stimulus(8'h11, 1'b1);
        repeat (3) @(negedge clk);
        apply_stimulus(8'h22, 1'b0);
        repeat (19) @(negedge clk);
        check_output("t3_frame_err", frame_err, 1);
        check_output("t3_count_kept", count, 1);
        check_output("t3_busy_in_brk", busy, 1);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        check_output("t3_busy_released", busy, 0);
        apply_stimulus(8'hA5, 1'b1);
        repeat (3) @(negedge clk);
        check_output("t3_count_after", count, 2);
        check_output("t3_frame_err_sticky", frame_err, 1);
        read_mem(4'd1, 8'hA5);
        read_mem(4'd0, 8'h11);

        $display("[TB] clear on stop-sample cycle");
        apply_stimulus(8'h5A, 1'b1);
        repeat (3) @(negedge clk);
        check_output("t6_count3", count, 3);
        apply_stimulus(8'h99, 1'b1);
        @(negedge clk);
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        check_output("t6_bv_pulse", byte_valid, 1);
        check_output("t6_count_cleared", count, 0);
        check_output("t6_err_cleared", frame_err, 0);
        read_mem(4'd3, 8'h0F);
        read_mem(4'd2, 8'h5A);

        $display("[TB] start glitch at 8 clocks per bit");
        @(negedge clk) rxd8 = 1'b0;
        @(negedge clk);
        @(negedge clk) rxd8 = 1'b1;
        begin
            logic saw_busy;
            saw_busy = 1'b0;
            repeat (20) @(negedge clk) if (busy8) saw_busy = 1'b1;
            check_output("t4_saw_busy", saw_busy, 1);
        end
        check_output("t4_busy_dropped", busy8, 0);
        check_output("t4_no_flags", {frame_err8, overrun8, count8}, 0);
        check_output("t4_no_bv", bv8_pulses, 0);
        send8(8'hC3);
        begin
            int waited;
            waited = 0;
            while (bv8_pulses == 0 && waited < 60) begin
                @(negedge clk);
                waited++;
            end
        end
        check_output("t4_bv8_pulses", bv8_pulses, 1);
        check_output("t4_bd8", byte_data8, 8'hC3);
        check_output("t4_count8", count8, 1);
        @(negedge clk) rd_addr8 = 4'd0;
        @(negedge clk) check_output("t4_mem8_0", rd_data8, 8'hC3);

        $display("[TB] reset mid-frame");
        @(negedge clk) rxd = 1'b0;
        for (int k = 0; k < 4; k++)
            @(negedge clk) rxd = k[0] ? 1'b1 : 1'b0;
        @(negedge clk) rxd = 1'b1;
        check_output("t5_busy_before", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check_output("t5_count0", count, 0);
        check_output("t5_flags0", {ack, frame_err, overrun, busy, byte_valid}, 0);
        check_output("t5_data0", {byte_data, rd_data}, 0);
        @(negedge clk) rxd = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        apply_stimulus(8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        check_output("t5_count_after", count, 1);
        read_mem(4'd0, 8'h3C);

        repeat (3) @(negedge clk);
        check_output("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
